// File: rtl/gascon_pkg.sv
// Shared definitions for the Gascon permutation sequencer.
//   ctrl_state_t      : sequencer FSM encoding
//   GASCON_CWIDTH     : permutation state width
//   GASCON_RWIDTH     : round-index width of the single-round core
//   GASCON_MAX_ROUNDS : highest supported round count
package gascon_pkg;

    localparam int unsigned GASCON_CWIDTH     = 320;
    localparam int unsigned GASCON_RWIDTH     = 4;
    localparam int unsigned GASCON_MAX_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/gascon_ctrl_watchdog.sv
// Per-round watchdog for the permutation sequencer.
//   clk, reset (async, active-low)
//   clear     : restart the count (sequencer in ARM)
//   run       : sequencer in RUN; counts one per cycle
//   core_done : round finished this cycle; suppresses expiry
//   expire    : TIMEOUT-th RUN cycle of a round passed without core_done
//   error     : sticky expiry flag, cleared only by reset
module gascon_ctrl_watchdog import gascon_pkg::*; #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic core_done,
    output logic expire,
    output logic error
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;
    logic         err_q;

    // cnt holds the number of RUN cycles already elapsed, so the TIMEOUT-th
    // RUN cycle is the one where cnt == TIMEOUT-1.
    assign expire = run && !core_done && (cnt == W'(TIMEOUT - 1));
    assign error  = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (run)
                cnt <= cnt + 1'b1;
            if (expire)
                err_q <= 1'b1;
        end
    end

endmodule

// File: rtl/gascon_perm_ctrl.sv
// Sequencer driving a single-round Gascon core through a full permutation.
// Latches state_in on start, then per round: ARM (core held in reset one
// cycle) followed by RUN until core_done, feeding core_cout back into the
// state register. FINISH pulses done for one cycle.
//   clk, reset (async, active-low)
//   start, nrounds, state_in : request, sampled in IDLE only
//   state_out, busy, done    : result / status
//   error                    : sticky watchdog flag (0 without the macro)
//   core_c, core_round, core_rst, core_done, core_cout : round-core link
// Optional: define GASCON_CTRL_TIMEOUT_EN to add the per-round watchdog.
module gascon_perm_ctrl import gascon_pkg::*; #(
    parameter int unsigned CWIDTH     = GASCON_CWIDTH,
    parameter int unsigned RWIDTH     = GASCON_RWIDTH,
    parameter int unsigned MAX_ROUNDS = GASCON_MAX_ROUNDS,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RWIDTH-1:0] nrounds,
    input  logic [CWIDTH-1:0] state_in,
    output logic [CWIDTH-1:0] state_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CWIDTH-1:0] core_c,
    output logic [RWIDTH-1:0] core_round,
    output logic              core_rst,
    input  logic              core_done,
    input  logic [CWIDTH-1:0] core_cout
);

    // MAX_ROUNDS itself must be representable: it is the idle round index.
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > (2 ** RWIDTH) - 1 || TIMEOUT < 1) begin : g_param_check
        $error("gascon_perm_ctrl: MAX_ROUNDS must fit in RWIDTH bits, TIMEOUT >= 1");
    end

    localparam logic [RWIDTH-1:0] MAX_R = RWIDTH'(MAX_ROUNDS);

    ctrl_state_t       state, state_n;
    logic [CWIDTH-1:0] state_q;
    logic [RWIDTH-1:0] cnt;
    logic [RWIDTH-1:0] first;
    logic [RWIDTH-1:0] round_idx;
    logic              last_round;
    logic              expire;

    // Rounds always end at MAX_ROUNDS-1, so the last round is the one whose
    // index plus one reaches MAX_ROUNDS; no separate round-count register.
    assign round_idx  = first + cnt;
    assign last_round = (round_idx + 1'b1) == MAX_R;

`ifdef GASCON_CTRL_TIMEOUT_EN
    gascon_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == ARM),
        .run       (state == RUN),
        .core_done (core_done),
        .expire    (expire),
        .error     (error)
    );
`else
    assign expire = 1'b0;
    assign error  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            state_q <= '0;
            cnt     <= '0;
            first   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    state_q <= state_in;
                    cnt     <= '0;
                    // Clamp over-long requests to the full permutation.
                    first   <= MAX_R - ((nrounds > MAX_R) ? MAX_R : nrounds);
                end
                RUN: if (core_done) begin
                    state_q <= core_cout;
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (nrounds == '0) ? FINISH : ARM;
            ARM:     state_n = RUN;
            RUN: begin
                if (core_done)
                    state_n = last_round ? FINISH : ARM;
                else if (expire)
                    state_n = FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign state_out  = state_q;
    assign core_c     = state_q;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign core_rst   = (state != RUN);
    // Outside a permutation the core sees an out-of-range index.
    assign core_round = (state == ARM || state == RUN) ? round_idx : MAX_R;

endmodule

// File: tb/tb_gascon_perm_ctrl.sv
// Directed bench for gascon_perm_ctrl. A behavioural core with latency 3
// returns c XOR {round replicated}. Define GASCON_CTRL_TIMEOUT_EN to also
// exercise the watchdog.
module tb_gascon_perm_ctrl;

    localparam int CW = 320;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] nrounds = '0;
    logic [CW-1:0] state_in = '0;
    logic [CW-1:0] state_out;
    logic          busy, done, error;
    logic [CW-1:0] core_c;
    logic [RW-1:0] core_round;
    logic          core_rst;
    logic          core_done;
    logic [CW-1:0] core_cout;

    int nchk = 0;
    int nerr = 0;

    gascon_perm_ctrl #(
        .CWIDTH(CW), .RWIDTH(RW), .MAX_ROUNDS(12), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .nrounds(nrounds),
        .state_in(state_in), .state_out(state_out), .busy(busy), .done(done),
        .error(error), .core_c(core_c), .core_round(core_round),
        .core_rst(core_rst), .core_done(core_done), .core_cout(core_cout)
    );

    always #5 clk = ~clk;

    // Core model: done on the 3rd cycle out of reset, cout = c ^ {80{round}}.
    logic [1:0] mcnt = '0;
    bit         stall = 1'b0;
    always @(posedge clk) begin
        if (core_rst)        mcnt <= '0;
        else if (mcnt != 2'd3) mcnt <= mcnt + 2'd1;
    end
    assign core_done = !core_rst && (mcnt == 2'd2) && !stall;
    assign core_cout = core_c ^ {80{core_round}};

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-run observations
    int          done_at, ndone, busy_bad;
    bit          rst_low;
    logic [63:0] seq;

    // Start at edge 0; observe cycles 1.. at negedges. poke_cyc: cycle in
    // which a stray start with ~sin is driven. rst_cyc: cycle in which reset
    // is pulled low (run then aborts after checking reset values).
    task automatic run_perm(input logic [RW-1:0] nr, input logic [CW-1:0] sin,
                            input int poke_cyc, input int rst_cyc);
        done_at = -1; ndone = 0; busy_bad = 0; rst_low = 0; seq = '0;
        @(negedge clk);
        start = 1'b1; nrounds = nr; state_in = sin;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == rst_cyc) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_state", state_out, 0);
                chk("rst_core_rst", core_rst, 1);
                chk("rst_round", core_round, 12);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (!core_rst) rst_low = 1;
            if (core_done) seq = {seq[59:0], core_round};
            if (busy !== ((done_at < 0) || (c == done_at))) busy_bad++;
            if (c == poke_cyc) begin
                start = 1'b1; state_in = ~sin;
            end else begin
                start = 1'b0; state_in = sin;
            end
            if (done_at > 0 && c >= done_at + 2) break;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string tag, input int exp_done, input logic [63:0] exp_seq,
                             input logic [CW-1:0] exp_state, input bit exp_rst_low);
        chk({tag, "_done_cyc"}, done_at, exp_done);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_rounds"}, seq, exp_seq);
        chk({tag, "_state"}, state_out, exp_state);
        chk({tag, "_core_rst_low"}, rst_low, exp_rst_low);
    endtask

    localparam logic [CW-1:0] P   = {10{32'hDEADBEEF}};
    localparam logic [CW-1:0] A5  = {40{8'hA5}};
    localparam logic [63:0]   S12 = 64'h0000_0123_4567_89AB;

    initial begin
        // Reset values while reset is held low
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_core_rst", core_rst, 1);
        chk("reset_round", core_round, 12);
        chk("reset_state", state_out, 0);
        reset = 1'b1;
        @(negedge clk);

        // Full 12-round run: rounds 0..11 XOR to zero
        run_perm(4'd12, '0, 0, 0);
        check_run("r12", 49, S12, '0, 1);

        // 6 rounds: 6..11, 6^7^8^9^10^11 = 1
        run_perm(4'd6, '0, 0, 0);
        check_run("r6", 25, 64'h0000_0000_0067_89AB, {80{4'h1}}, 1);

        // Zero rounds, with a stray start in the FINISH cycle
        run_perm(4'd0, A5, 1, 0);
        check_run("r0", 1, 64'h0, A5, 0);

        // Clamp 15 -> 12
        run_perm(4'd15, P, 0, 0);
        check_run("clamp", 49, S12, P, 1);

        // Start while busy is ignored
        run_perm(4'd12, P, 5, 0);
        check_run("busy_start", 49, S12, P, 1);

        // 3 rounds: 9^10^11 = 8
        run_perm(4'd3, P, 0, 0);
        check_run("r3", 13, 64'h0000_0000_0000_09AB, P ^ {80{4'h8}}, 1);

        // Reset mid-run, then recover with a single round (index 11)
        run_perm(4'd12, P, 0, 20);
        chk("post_rst_busy", busy, 0);
        run_perm(4'd1, P, 0, 0);
        check_run("r1", 5, 64'h0000_0000_0000_000B, P ^ {80{4'hB}}, 1);
        chk("no_error", error, 0);

`ifdef GASCON_CTRL_TIMEOUT_EN
        // Core never answers: 64 RUN cycles (2..65), FINISH in cycle 66
        stall = 1'b1;
        run_perm(4'd12, P, 0, 0);
        stall = 1'b0;
        check_run("wdog", 66, 64'h0, P, 1);
        chk("wdog_error", error, 1);
        repeat (3) @(negedge clk);
        chk("wdog_sticky", error, 1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/gascon_perm_ctrl.md
# gascon_perm_ctrl

Sequencer that drives the single-round Gascon core through a full permutation of 0..MAX_ROUNDS rounds. It latches a 320-bit state on `start` and issues one round index per pass. It resets the core between rounds, waits for the core's `done`, and feeds `cout` back as the next input. It sits between the AEAD mode FSM (init/absorb/squeeze) and `Gascon_Core_Round`.

## Interface
Parameters:
- `CWIDTH`, 320, permutation state width in bits.
- `RWIDTH`, 4, round-index width; must match the core's `round` input.
- `MAX_ROUNDS`, 12, highest supported round count.
- `TIMEOUT`, 64, watchdog limit in cycles; used only with `GASCON_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all flops clear while low.
- `start`  in  1  one-cycle request, sampled in IDLE only.
- `nrounds`  in  RWIDTH  rounds to run, sampled with `start`.
- `state_in`  in  CWIDTH  permutation input, sampled with `start`.
- `state_out`  out  CWIDTH  current state register.
- `busy`  out  1  high from the cycle after `start` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky watchdog flag; tied 0 without the macro.
- `core_c`  out  CWIDTH  to core `c`.
- `core_round`  out  RWIDTH  to core `round`.
- `core_rst`  out  1  to core `reset` (active-high).
- `core_done`  in  1  from core `done`.
- `core_cout`  in  CWIDTH  from core `cout`.

## Operation
- States: IDLE, ARM, RUN, FINISH.
- **IDLE**
  - `core_rst`=1.
  - On `start`: `state_q` ← `state_in`, `cnt` ← 0.
  - `first` ← MAX_ROUNDS − min(`nrounds`, MAX_ROUNDS).
  - Go to FINISH if the effective round count is 0; otherwise go to ARM.
- **ARM**: `core_rst`=1 for exactly one cycle → RUN.
- **RUN**
  - `core_rst`=0.
  - When `core_done` is 1: `state_q` ← `core_cout`, `cnt` ← `cnt`+1.
  - If `cnt`+1 equals the effective round count → FINISH; else → ARM.
- **FINISH**: `done`=1, `busy`=1 → IDLE.
- `core_c` = `state_q`; `core_round` = `first` + `cnt`. Both are stable throughout ARM and RUN.
- `nrounds` > MAX_ROUNDS is clamped to MAX_ROUNDS. No error is raised.
- `start` while not in IDLE is ignored; there is no queueing.
- `core_done` outside RUN is ignored.
- Round-index arithmetic is RWIDTH-bit unsigned. `first` + `cnt` ≤ MAX_ROUNDS−1 always, so there is no wrap.

## Timing
- Reset values:
  - state IDLE, `state_q`=0, `cnt`=0, `first`=0.
  - `busy`=0, `done`=0, `error`=0, `core_rst`=1, `core_round`=MAX_ROUNDS.
- Core latency L = number of RUN cycles up to and including the cycle in which `core_done` is high.
- `start` sampled at edge 0:
  - ARM in cycle 1; RUN in cycles 2..L+1; the capture edge ends cycle L+1.
  - Each round costs L+1 cycles.
  - For N rounds, `done` is high in cycle N(L+1)+1. For N=0, `done` is high in cycle 1.
- `state_out` holds the final value from the FINISH cycle until the next accepted `start`.
- `reset` low mid-permutation: immediate return to reset values, no `done` pulse, partial state discarded.
- `core_done` and FINISH never coincide. `start` during the FINISH cycle is ignored.

## Configuration
- `GASCON_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts RUN cycles per round.
  - Reaching TIMEOUT without `core_done` causes:
    - `error` ← 1, sticky until `reset`;
    - go to FINISH, with `done` pulsed and `state_q` unchanged.
  - The counter clears in ARM.
- Undefined: no watchdog logic; `error` is constant 0; RUN waits indefinitely.

## Structure
- Shared package `gascon_pkg`:
  - `ctrl_state_t` enum (IDLE, ARM, RUN, FINISH);
  - `GASCON_CWIDTH`=320, `GASCON_RWIDTH`=4, `GASCON_MAX_ROUNDS`=12.
- One sub-module: `gascon_ctrl_watchdog` (counter plus compare). It is instantiated only under `GASCON_CTRL_TIMEOUT_EN`.
- The round core is not instantiated inside this block; the integrator wires it.

## Test plan
- The bench models the core with fixed L=3 and `core_cout` = `core_c` XOR {`core_round` replicated}.
- **12-round run**: `nrounds`=12, `state_in`=0 → `core_round` sequence 0..11; `done` in cycle 49; `state_out` matches the model.
- **Short run**: `nrounds`=6 → `core_round` sequence 6..11; `done` in cycle 25; `busy` high in cycles 1..25.
- **Zero rounds**: `nrounds`=0, `state_in`=0xA5…A5 → `done` in cycle 1; `state_out`=0xA5…A5; `core_rst` never deasserts.
- **Clamp**: `nrounds`=15 → behaves as 12.
- **Start while busy**: pulse `start` in cycle 5 with a different `state_in` → ignored; result is identical to the single 12-round run.
- **Reset mid-run**: `reset` low in cycle 20 → `busy`=0, `done`=0, `state_out`=0, `core_rst`=1 in the same cycle.
- **Watchdog** (macro on, TIMEOUT=64): core model never asserts `done` → `error`=1 and `done` pulse 64 RUN cycles after ARM; `state_out` equals `state_in`.
